// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: multi-port register file with a per-register busy scoreboard.
//
// Two combinational read ports, two synchronous write ports (port B wins on an
// address clash), optional hardwired-zero register 0 and optional same-cycle
// write-to-read bypass. The scoreboard holds one busy bit per register: an
// issue sets it, a write clears it, and busy_count tracks how many are set.
//
// Ports:
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   rd_addr_n / rd_data_n    read address / combinational read data (n = 1, 2)
//   rd_busy_n                scoreboard busy for rd_addr_n
//   we_a, wr_addr_a, wr_data_a   write port A
//   we_b, wr_addr_b, wr_data_b   write port B (priority)
//   issue_en, issue_addr     mark a destination register busy
//   busy_count               registered popcount of the busy vector
module regfile_scoreboard #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rd_addr_1,
    input  logic [ADDR_W-1:0] rd_addr_2,
    output logic [DATA_W-1:0] rd_data_1,
    output logic [DATA_W-1:0] rd_data_2,
    output logic              rd_busy_1,
    output logic              rd_busy_2,
    input  logic              we_a,
    input  logic [ADDR_W-1:0] wr_addr_a,
    input  logic [DATA_W-1:0] wr_data_a,
    input  logic              we_b,
    input  logic [ADDR_W-1:0] wr_addr_b,
    input  logic [DATA_W-1:0] wr_data_b,
    input  logic              issue_en,
    input  logic [ADDR_W-1:0] issue_addr,
    output logic [ADDR_W:0]   busy_count
);

    localparam int unsigned NUM_REGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic [ADDR_W:0]     busy_count_q, busy_count_d;

    // Effective enables: with a hardwired zero register, anything aimed at
    // address 0 is dropped here, which also keeps it out of the bypass path.
    logic we_a_eff, we_b_eff, issue_eff;

    always_comb begin
        we_a_eff  = we_a;
        we_b_eff  = we_b;
        issue_eff = issue_en;
        if (ZERO_REG != 0) begin
            if (wr_addr_a == '0)  we_a_eff  = 1'b0;
            if (wr_addr_b == '0)  we_b_eff  = 1'b0;
            if (issue_addr == '0) issue_eff = 1'b0;
        end
    end

    // Scoreboard next state: writes clear first, then an issue sets, so a
    // same-cycle issue and write leaves the register busy for the new producer.
    always_comb begin
        busy_d = busy_q;
        if (we_a_eff)  busy_d[wr_addr_a]  = 1'b0;
        if (we_b_eff)  busy_d[wr_addr_b]  = 1'b0;
        if (issue_eff) busy_d[issue_addr] = 1'b1;

        busy_count_d = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            busy_count_d = busy_count_d + (ADDR_W + 1)'(busy_d[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            busy_q       <= '0;
            busy_count_q <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (we_b_eff && wr_addr_b == ADDR_W'(i)) begin
                    regs_q[i] <= wr_data_b;
                end else if (we_a_eff && wr_addr_a == ADDR_W'(i)) begin
                    regs_q[i] <= wr_data_a;
                end
            end
            busy_q       <= busy_d;
            busy_count_q <= busy_count_d;
        end
    end

    assign busy_count = busy_count_q;

    // Read ports. Register 0 under ZERO_REG is reset to 0 and never written,
    // and its enables are masked above, so no extra zero mux is needed.
    logic [ADDR_W-1:0] rd_addr [2];
    logic [DATA_W-1:0] rd_data [2];
    logic              rd_busy [2];

    assign rd_addr[0] = rd_addr_1;
    assign rd_addr[1] = rd_addr_2;

    for (genvar p = 0; p < 2; p++) begin : g_rd
        logic hit_a, hit_b;

        assign hit_a = we_a_eff && (wr_addr_a == rd_addr[p]);
        assign hit_b = we_b_eff && (wr_addr_b == rd_addr[p]);

        always_comb begin
            rd_data[p] = regs_q[rd_addr[p]];
            rd_busy[p] = busy_q[rd_addr[p]];
            if (BYPASS != 0) begin
                if (hit_b) begin
                    rd_data[p] = wr_data_b;
                end else if (hit_a) begin
                    rd_data[p] = wr_data_a;
                end
                // Forwarded data is final, so the consumer need not stall.
                if (hit_a || hit_b) begin
                    rd_busy[p] = 1'b0;
                end
            end
        end
    end

    assign rd_data_1 = rd_data[0];
    assign rd_data_2 = rd_data[1];
    assign rd_busy_1 = rd_busy[0];
    assign rd_busy_2 = rd_busy[1];

endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard: scoreboard bench for regfile_scoreboard.
//
// Two instances share all inputs: u_byp (ZERO_REG=1, BYPASS=1) and u_nob
// (ZERO_REG=0, BYPASS=0). A driver applies directed then random stimulus and
// pushes the expected outputs of each instance into its queue; a monitor pops
// and compares on the falling edge.
module tb_regfile_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rd_addr_1, rd_addr_2;
    logic        we_a, we_b, issue_en;
    logic [4:0]  wr_addr_a, wr_addr_b, issue_addr;
    logic [31:0] wr_data_a, wr_data_b;

    logic [31:0] byp_rd_data_1, byp_rd_data_2, nob_rd_data_1, nob_rd_data_2;
    logic        byp_rd_busy_1, byp_rd_busy_2, nob_rd_busy_1, nob_rd_busy_2;
    logic [5:0]  byp_busy_count, nob_busy_count;

    always #5 clk = ~clk;

    regfile_scoreboard #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) u_byp (
        .clk(clk), .rst(rst),
        .rd_addr_1(rd_addr_1), .rd_addr_2(rd_addr_2),
        .rd_data_1(byp_rd_data_1), .rd_data_2(byp_rd_data_2),
        .rd_busy_1(byp_rd_busy_1), .rd_busy_2(byp_rd_busy_2),
        .we_a(we_a), .wr_addr_a(wr_addr_a), .wr_data_a(wr_data_a),
        .we_b(we_b), .wr_addr_b(wr_addr_b), .wr_data_b(wr_data_b),
        .issue_en(issue_en), .issue_addr(issue_addr),
        .busy_count(byp_busy_count)
    );

    regfile_scoreboard #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(0), .BYPASS(0)) u_nob (
        .clk(clk), .rst(rst),
        .rd_addr_1(rd_addr_1), .rd_addr_2(rd_addr_2),
        .rd_data_1(nob_rd_data_1), .rd_data_2(nob_rd_data_2),
        .rd_busy_1(nob_rd_busy_1), .rd_busy_2(nob_rd_busy_2),
        .we_a(we_a), .wr_addr_a(wr_addr_a), .wr_data_a(wr_data_a),
        .we_b(we_b), .wr_addr_b(wr_addr_b), .wr_data_b(wr_data_b),
        .issue_en(issue_en), .issue_addr(issue_addr),
        .busy_count(nob_busy_count)
    );

    typedef struct {
        logic        rst;
        logic [4:0]  rd1, rd2;
        logic        we_a;
        logic [4:0]  wa;
        logic [31:0] da;
        logic        we_b;
        logic [4:0]  wb;
        logic [31:0] db;
        logic        iss;
        logic [4:0]  ia;
    } stim_t;

    typedef struct {
        bit          chk;
        logic [31:0] d1, d2;
        logic        b1, b2;
        logic [5:0]  cnt;
    } exp_t;

    // Reference model, index 0 = u_byp configuration, 1 = u_nob configuration.
    logic [31:0] m_regs [2][32];
    bit          m_busy [2][32];

    exp_t q_byp [$];
    exp_t q_nob [$];

    int total = 0;
    int bad   = 0;

    function automatic logic [31:0] m_read(int c, logic [4:0] a, stim_t s);
        bit zr  = (c == 0);
        bit byp = (c == 0);
        if (zr && a == 0) return 32'd0;
        if (byp && s.we_b && s.wb == a) return s.db;
        if (byp && s.we_a && s.wa == a) return s.da;
        return m_regs[c][a];
    endfunction

    function automatic logic m_rbusy(int c, logic [4:0] a, stim_t s);
        bit byp = (c == 0);
        if (byp && ((s.we_a && s.wa == a) || (s.we_b && s.wb == a))) return 1'b0;
        return m_busy[c][a];
    endfunction

    function automatic exp_t m_expect(int c, stim_t s, bit chk);
        exp_t e;
        int   n = 0;
        for (int i = 0; i < 32; i++) n += int'(m_busy[c][i]);
        e.chk = chk;
        e.d1  = m_read(c, s.rd1, s);
        e.d2  = m_read(c, s.rd2, s);
        e.b1  = m_rbusy(c, s.rd1, s);
        e.b2  = m_rbusy(c, s.rd2, s);
        e.cnt = 6'(n);
        return e;
    endfunction

    task automatic m_update(int c, stim_t s);
        bit zr = (c == 0);
        if (s.rst) begin
            for (int i = 0; i < 32; i++) begin
                m_regs[c][i] = 32'd0;
                m_busy[c][i] = 1'b0;
            end
            return;
        end
        if (s.we_a && !(zr && s.wa == 0)) begin
            m_regs[c][s.wa] = s.da;
            m_busy[c][s.wa] = 1'b0;
        end
        if (s.we_b && !(zr && s.wb == 0)) begin
            m_regs[c][s.wb] = s.db;
            m_busy[c][s.wb] = 1'b0;
        end
        if (s.iss && !(zr && s.ia == 0)) m_busy[c][s.ia] = 1'b1;
    endtask

    function automatic stim_t idle(logic [4:0] r1, logic [4:0] r2);
        stim_t s;
        s = '{rst: 1'b0, rd1: r1, rd2: r2, we_a: 1'b0, wa: 5'd0, da: 32'd0,
              we_b: 1'b0, wb: 5'd0, db: 32'd0, iss: 1'b0, ia: 5'd0};
        return s;
    endfunction

    // Drive one cycle of stimulus just after the rising edge, queue the
    // expected outputs for that cycle, then advance the model past the next edge.
    task automatic step(stim_t s, bit chk);
        @(posedge clk);
        #1;
        rst        = s.rst;
        rd_addr_1  = s.rd1;
        rd_addr_2  = s.rd2;
        we_a       = s.we_a;
        wr_addr_a  = s.wa;
        wr_data_a  = s.da;
        we_b       = s.we_b;
        wr_addr_b  = s.wb;
        wr_data_b  = s.db;
        issue_en   = s.iss;
        issue_addr = s.ia;
        q_byp.push_back(m_expect(0, s, chk));
        q_nob.push_back(m_expect(1, s, chk));
        m_update(0, s);
        m_update(1, s);
    endtask

    task automatic cmp(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q_byp.size() > 0) begin
            e = q_byp.pop_front();
            if (e.chk) begin
                cmp("byp rd_data_1", byp_rd_data_1, e.d1);
                cmp("byp rd_data_2", byp_rd_data_2, e.d2);
                cmp("byp rd_busy_1", 32'(byp_rd_busy_1), 32'(e.b1));
                cmp("byp rd_busy_2", 32'(byp_rd_busy_2), 32'(e.b2));
                cmp("byp busy_count", 32'(byp_busy_count), 32'(e.cnt));
            end
        end
        if (q_nob.size() > 0) begin
            e = q_nob.pop_front();
            if (e.chk) begin
                cmp("nob rd_data_1", nob_rd_data_1, e.d1);
                cmp("nob rd_data_2", nob_rd_data_2, e.d2);
                cmp("nob rd_busy_1", 32'(nob_rd_busy_1), 32'(e.b1));
                cmp("nob rd_busy_2", 32'(nob_rd_busy_2), 32'(e.b2));
                cmp("nob busy_count", 32'(nob_busy_count), 32'(e.cnt));
            end
        end
    end

    initial begin
        stim_t s;
        int    waited;

        rst = 1'b1;
        rd_addr_1 = '0; rd_addr_2 = '0;
        we_a = 1'b0; we_b = 1'b0; issue_en = 1'b0;
        wr_addr_a = '0; wr_addr_b = '0; issue_addr = '0;
        wr_data_a = '0; wr_data_b = '0;
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 32; j++) begin
                m_regs[i][j] = 32'd0;
                m_busy[i][j] = 1'b0;
            end
        end

        // 1: reset, then read 2 and 5. State is unknown before the first edge.
        s = idle(5'd2, 5'd5); s.rst = 1'b1; step(s, 1'b0);
        step(idle(5'd2, 5'd5), 1'b1);

        // 2: write 25 to reg 2 while reading it, then read it again.
        s = idle(5'd2, 5'd5); s.we_a = 1'b1; s.wa = 5'd2; s.da = 32'd25; step(s, 1'b1);
        step(idle(5'd2, 5'd5), 1'b1);

        // 3: both ports to reg 5, B wins.
        s = idle(5'd5, 5'd2);
        s.we_a = 1'b1; s.wa = 5'd5; s.da = 32'd7;
        s.we_b = 1'b1; s.wb = 5'd5; s.db = 32'd9;
        step(s, 1'b1);
        step(idle(5'd5, 5'd2), 1'b1);

        // 4: issue reg 3, then write it.
        s = idle(5'd3, 5'd2); s.iss = 1'b1; s.ia = 5'd3; step(s, 1'b1);
        s = idle(5'd3, 5'd2); s.we_a = 1'b1; s.wa = 5'd3; s.da = 32'd40; step(s, 1'b1);
        step(idle(5'd3, 5'd2), 1'b1);

        // 5: issue and write together on reg 4, then on reg 0.
        s = idle(5'd4, 5'd0); s.iss = 1'b1; s.ia = 5'd4;
        s.we_a = 1'b1; s.wa = 5'd4; s.da = 32'd44; step(s, 1'b1);
        step(idle(5'd4, 5'd0), 1'b1);
        s = idle(5'd0, 5'd4); s.iss = 1'b1; s.ia = 5'd0;
        s.we_a = 1'b1; s.wa = 5'd0; s.da = 32'd99; step(s, 1'b1);
        step(idle(5'd0, 5'd4), 1'b1);

        // 6: issue 1..6, then reset mid-operation.
        for (int i = 1; i <= 6; i++) begin
            s = idle(5'(i), 5'd6); s.iss = 1'b1; s.ia = 5'(i); step(s, 1'b1);
        end
        step(idle(5'd1, 5'd6), 1'b1);
        s = idle(5'd2, 5'd5); s.rst = 1'b1; step(s, 1'b1);
        step(idle(5'd2, 5'd5), 1'b1);
        step(idle(5'd4, 5'd3), 1'b1);

        // Random traffic, mostly on a small address window to force clashes.
        for (int n = 0; n < 400; n++) begin
            s.rst  = ($urandom_range(0, 59) == 0);
            s.rd1  = 5'($urandom_range(0, 3) == 0 ? $urandom_range(0, 31) : $urandom_range(0, 7));
            s.rd2  = 5'($urandom_range(0, 7));
            s.we_a = 1'($urandom_range(0, 1));
            s.wa   = 5'($urandom_range(0, 7));
            s.da   = $urandom;
            s.we_b = 1'($urandom_range(0, 2) == 0);
            s.wb   = 5'($urandom_range(0, 7));
            s.db   = $urandom;
            s.iss  = 1'($urandom_range(0, 1));
            s.ia   = 5'($urandom_range(0, 3) == 0 ? $urandom_range(0, 31) : $urandom_range(0, 7));
            step(s, 1'b1);
        end

        // Let the monitor drain both queues, bounded.
        waited = 0;
        while ((q_byp.size() > 0 || q_nob.size() > 0) && waited < 20) begin
            @(posedge clk);
            waited++;
        end
        if (q_byp.size() > 0 || q_nob.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending want 0", q_byp.size() + q_nob.size());
        end
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1, "timeout");
    end

endmodule
